// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the CPU memories.
package imem_loader_pkg;
   localparam int ADDR_W_DEFAULT = 10;
   localparam int DEPTH_DEFAULT  = 1 << ADDR_W_DEFAULT;
   localparam int BYTES_PER_WORD = 4;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD);
   localparam int WORD_W         = 8 * BYTES_PER_WORD;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian word from a byte stream; byte k lands in lane k.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              en,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word,
   output logic              word_ready
);
   logic [IDX_W-1:0] idx;
   logic             take;

   assign take       = en && load;
   // Combinational so the FSM can leave RECV on the same edge as the last byte.
   assign word_ready = take && (idx == IDX_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx  <= '0;
         word <= '0;
      end else if (clear) begin
         idx  <= '0;
         word <= '0;
      end else if (take) begin
         word[{idx, 3'b000} +: 8] <= byte_in;
         idx                      <= idx + 1'b1;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream and holds the CPU in reset until done.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DEPTH  = DEPTH_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len_words,
   input  logic              abort,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   state_t            state, state_nxt;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   count;
   logic              err_q;
   logic              can_start, len_zero, len_big;
   logic              pk_clear, word_ready;
   logic [WORD_W-1:0] word;

   assign can_start = start && (state == IDLE || state == DONE);
   assign len_zero  = (len_words == '0);
   assign len_big   = (len_words > DEPTH_L);

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (pk_clear),
      .load       (rx_valid),
      .en         (state == RECV),
      .byte_in    (rx_data),
      .word       (word),
      .word_ready (word_ready)
   );

   always_comb begin
      state_nxt = state;
      pk_clear  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               if (len_big) begin
                  state_nxt = IDLE;
               end else if (len_zero) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = RECV;
                  pk_clear  = 1'b1;
               end
            end
         end
         RECV: begin
            // Abort beats a completing byte; the partial word is dropped.
            if (abort) begin
               state_nxt = IDLE;
               pk_clear  = 1'b1;
            end else if (word_ready) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (abort)                         state_nxt = IDLE;
            else if (count + 1'b1 == len_q)    state_nxt = DONE;
            else                               state_nxt = RECV;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         len_q <= '0;
         count <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (can_start) begin
            // err reflects only the most recent start request.
            err_q <= len_big;
            if (!len_big) begin
               len_q <= len_words;
               count <= '0;
            end
         end else if (state == WRITE) begin
            count <= count + 1'b1;
         end
      end
   end

   assign rx_ready  = (state == RECV);
   assign mem_we    = (state == WRITE);
   assign mem_addr  = count[ADDR_W-1:0];
   assign mem_wdata = word;
   assign busy      = (state == RECV) || (state == WRITE);
   assign done      = (state == DONE);
   assign cpu_rst   = (state != DONE);
   assign err       = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-rule table, directed corner cases, random loads.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W:0]   len_words = '0;
   logic [7:0]        rx_data = '0;
   logic              rx_valid = 1'b0;
   logic              rx_ready, mem_we, cpu_rst, busy, done, err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len_words (len_words),
      .abort     (abort),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [ADDR_W:0] len;
      logic            e_done, e_err, e_cpu, e_busy, e_rdy;
   } vec_t;

   wr_t wq[$];
   int  cyc = 0;
   int  rdy_drop = 0;
   int  total = 0;
   int  bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Write log plus a watch on rx_ready whenever a load is receiving.
   always @(negedge clk) begin
      if (mem_we) wq.push_back('{int'(mem_addr), mem_wdata, cyc});
      if (busy && !mem_we && !rx_ready) rdy_drop <= rdy_drop + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic put_byte(input logic [7:0] b, input bit gap);
      int n = 0;
      if (gap) begin
         rx_valid = 1'b0;
         tick();
      end
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 20) begin
         tick();
         n++;
      end
      if (!rx_ready) chk("rx_ready_timeout", 0, 1);
      tick();
   endtask

   // gap_mode: 0 back-to-back, 1 valid toggled, 2 random gaps
   task automatic send(input logic [7:0] bs[$], input int gap_mode);
      bit g;
      for (int i = 0; i < bs.size(); i++) begin
         g = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         put_byte(bs[i], g);
      end
      rx_valid = 1'b0;
   endtask

   task automatic do_start(input int len);
      len_words = (ADDR_W + 1)'(len);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int lim);
      int n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
      chk(name, done, 1);
   endtask

   function automatic logic [31:0] word_of(input logic [7:0] bs[$], input int w);
      return 32'(bs[4*w]) + 32'(bs[4*w+1]) * 256 + 32'(bs[4*w+2]) * 65536
             + 32'(bs[4*w+3]) * 16777216;
   endfunction

   task automatic check_writes(input string name, input int ws, input logic [7:0] bs[$]);
      int nw = bs.size() / 4;
      chk({name, "_count"}, 64'(wq.size() - ws), 64'(nw));
      for (int i = 0; i < nw && ws + i < wq.size(); i++) begin
         chk({name, "_addr"}, 64'(wq[ws+i].addr), 64'(i));
         chk({name, "_data"}, wq[ws+i].data, word_of(bs, i));
      end
   endtask

   initial begin
      vec_t        tbl[5];
      logic [7:0]  bs[$];
      int          ws, d0, errs;

      tbl[0] = '{11'd0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{11'd1025, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{11'd1,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{11'd1024, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{11'd2047, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      do_reset();
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         ws = wq.size();
         do_start(int'(tbl[i].len));
         chk("tbl_done", done, tbl[i].e_done);
         chk("tbl_err", err, tbl[i].e_err);
         chk("tbl_cpu_rst", cpu_rst, tbl[i].e_cpu);
         chk("tbl_busy", busy, tbl[i].e_busy);
         chk("tbl_rx_ready", rx_ready, tbl[i].e_rdy);
         tick();
         chk("tbl_no_write", 64'(wq.size() - ws), 0);
      end

      // Two words back-to-back.
      do_reset();
      bs = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h00};
      ws = wq.size();
      do_start(2);
      send(bs, 0);
      chk("b2b_we_after_4th", mem_we, 1);
      tick();
      chk("b2b_done", done, 1);
      chk("b2b_cpu_rst", cpu_rst, 0);
      check_writes("b2b", ws, bs);
      if (wq.size() - ws == 2) chk("b2b_spacing", 64'(wq[ws+1].cyc - wq[ws].cyc), 5);
      else chk("b2b_spacing_count", 64'(wq.size() - ws), 2);

      // Same stream with rx_valid toggled, restarted straight from DONE.
      ws = wq.size();
      d0 = rdy_drop;
      do_start(2);
      chk("tog_cpu_rst_restart", cpu_rst, 1);
      chk("tog_done_restart", done, 0);
      send(bs, 1);
      wait_done("tog_done", 20);
      check_writes("tog", ws, bs);
      chk("tog_rdy_held", 64'(rdy_drop - d0), 0);

      // err is sticky while idle.
      do_reset();
      do_start(1025);
      repeat (3) tick();
      chk("err_sticky", err, 1);
      chk("err_cpu_rst", cpu_rst, 1);
      chk("err_idle", busy | done | rx_ready, 0);

      // Abort mid-word, then a fresh one-word load.
      do_reset();
      ws = wq.size();
      do_start(2);
      put_byte(8'h11, 1'b0);
      put_byte(8'h22, 1'b0);
      rx_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_cpu_rst", cpu_rst, 1);
      chk("abort_done", done, 0);
      bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_start(1);
      send(bs, 0);
      wait_done("abort_reload_done", 20);
      check_writes("abort_reload", ws, bs);

      // Random loads against the byte-to-word reference.
      for (int it = 0; it < 6; it++) begin
         int nw = $urandom_range(1, 6);
         bs.delete();
         for (int k = 0; k < 4 * nw; k++) bs.push_back(8'($urandom_range(0, 255)));
         ws = wq.size();
         do_start(nw);
         send(bs, 2);
         wait_done("rnd_done", 40);
         check_writes("rnd", ws, bs);
      end

      // Asynchronous reset during a write cycle.
      bs = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_start(3);
      send(bs, 0);
      chk("arst_pre_we", mem_we, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_mem_we", mem_we, 0);
      chk("arst_cpu_rst", cpu_rst, 1);
      chk("arst_busy", busy, 0);
      chk("arst_rx_ready", rx_ready, 0);
      tick();
      rst = 1'b0;
      bs = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      ws = wq.size();
      do_start(2);
      send(bs, 0);
      wait_done("arst_reload_done", 20);
      check_writes("arst_reload", ws, bs);

      // Full-depth load, word value = address.
      bs.delete();
      for (int a = 0; a < DEPTH; a++) begin
         bs.push_back(8'(a % 256));
         bs.push_back(8'(a / 256));
         bs.push_back(8'h00);
         bs.push_back(8'h00);
      end
      ws = wq.size();
      do_start(DEPTH);
      send(bs, 0);
      wait_done("full_done", 20);
      repeat (4) tick();
      chk("full_count", 64'(wq.size() - ws), DEPTH);
      errs = 0;
      for (int i = 0; i < DEPTH && ws + i < wq.size(); i++)
         if (wq[ws+i].addr != i || wq[ws+i].data !== 32'(i)) errs++;
      chk("full_contents", 64'(errs), 0);
      if (wq.size() > 0) begin
         chk("full_last_addr", 64'(wq[wq.size()-1].addr), 1023);
         chk("full_last_data", wq[wq.size()-1].data, 32'h0000_03FF);
      end
      chk("full_cpu_rst", cpu_rst, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader for the multi-cycle RISC-V CPU. It runs in the opposite direction to the end-of-run register readout: it fills instruction memory before execution starts.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to instruction memory at sequential word addresses from 0.
- Holds the CPU in reset until the requested number of words has been written, then releases it.
- Sits between the bench/host byte source and the CPU's instruction-memory write port.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 1024, instruction-memory depth in words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a load; sampled only in IDLE or DONE.
- len_words  input  ADDR_W+1  number of words to load; sampled with start.
- abort  input  1  cancel an in-progress load.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  word to write.
- cpu_rst  output  1  holds the CPU in reset while high.
- busy  output  1  a load is in progress.
- done  output  1  load complete; CPU released.
- err  output  1  sticky: last start was rejected because len_words > DEPTH.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - State = IDLE; word count, byte index and assembly register all 0.
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
  - cpu_rst=1.
- States: IDLE, RECV, WRITE, DONE. All outputs are registered or decoded from state.
- IDLE:
  - cpu_rst=1.
  - start with len_words in 1..DEPTH: latch len, clear count/byte index and err, go to RECV.
  - start with len_words=0: go to DONE with no writes.
  - start with len_words>DEPTH: set err=1, stay IDLE.
- RECV:
  - rx_ready=1, busy=1, cpu_rst=1.
  - A byte transfers only when rx_valid && rx_ready.
  - Byte k (k=0..3) goes to word bits [8k+7:8k]; first byte is the LSB.
  - On the 4th accepted byte, go to WRITE.
  - rx_valid low: hold state, nothing changes.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_addr=count[ADDR_W-1:0], mem_wdata=assembled word.
  - rx_ready=0, busy=1.
  - Then count+1. If count+1 == len, go to DONE; else go to RECV with byte index 0.
- Throughput: back-to-back bytes give one word per 5 cycles. mem_we is asserted in the cycle after the 4th byte handshake.
- DONE:
  - done=1, busy=0, cpu_rst=0, rx_ready=0.
  - start re-enters the IDLE start rules in the same cycle: cpu_rst=1 from the next cycle, done=0.
- abort in RECV or WRITE:
  - Go to IDLE next cycle.
  - Partial word discarded. An abort during WRITE still completes that cycle's write.
  - cpu_rst stays 1, done=0.
  - abort in IDLE/DONE is ignored.
- start while in RECV/WRITE is ignored. Simultaneous start and abort in RECV: abort wins.
- Address range: addresses never wrap. len ≤ DEPTH guarantees mem_addr ≤ DEPTH-1.
- Bytes offered outside RECV are not accepted (rx_ready=0). The source must hold them.
- Reset mid-load: immediate return to reset values. The memory contents already written are left untouched.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, RECV, WRITE, DONE);
  - BYTES_PER_WORD=4;
  - the ADDR_W/DEPTH defaults also used by the CPU memories.
- A sub-module byte_packer is natural: 2-bit byte index, 32-bit shift/assembly register, word_ready pulse. It has clear, load and enable inputs and is driven by the loader FSM.

Test Plan:
- Load 2 words, bytes 13,00,50,00 then B3,00,31,00, rx_valid held high:
  - mem_we pulses at addr 0 with 0x00500013, then addr 1 with 0x003100B3;
  - 5 cycles apart;
  - done=1 and cpu_rst=0 on the cycle after the second write.
- Same stream with rx_valid toggled every other cycle: identical writes and data; rx_ready never drops in RECV; no byte is lost or duplicated.
- start with len_words=0: DONE next cycle, no mem_we, cpu_rst=0. With len_words=1025: err=1, state stays IDLE, cpu_rst=1.
- abort after 2 bytes of word 1, then restart with len_words=1 and bytes AA,BB,CC,DD:
  - addr 0 written with 0xDDCCBBAA;
  - the aborted partial bytes do not appear.
- Load DEPTH=1024 words of value = address:
  - last write at addr 1023 with 0x000003FF;
  - no write to any other address after that;
  - done asserted.
- Assert rst asynchronously mid-word (between clock edges):
  - outputs immediately take their reset values (cpu_rst=1, mem_we=0);
  - a subsequent full load completes normally.
